multicycle_control_fsm: RTL and testbench

Main control state machine for the multi-cycle RV32I core. Sequences fetch, decode, execute, memory and writeback over several cycles per instruction. Drives the register-file, operand-mux, ALU, PC and memory-handshake controls. Publishes the current stage number, which the register file uses to qualify its read and writeback cycles.

---
 rtl/multicycle_control_fsm_pkg.sv | 47 ++++
 rtl/multicycle_control_fsm_if.sv | 10 +
 rtl/multicycle_control_fsm_decode.sv | 28 ++
 rtl/multicycle_control_fsm.sv | 153 +++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, stage
// numbers, instruction classes and datapath mux/ALU select values.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_ALU   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_WB_LD    = 4'd10,
    S_JUMP     = 4'd11,
    S_WB_J     = 4'd12,
    S_JALR_TGT = 4'd13,
    S_WB_U     = 4'd14,
    S_TRAP     = 4'd15
  } stage_e;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_NOP
  } inst_class_e;

  typedef enum logic [1:0] {MTOR_ALUOUT = 2'd0, MTOR_LOAD = 2'd1, MTOR_IMM = 2'd2} mtor_e;
  typedef enum logic [1:0] {SRCB_RS2 = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2} srcb_e;
  typedef enum logic       {SRCA_PC = 1'b0, SRCA_RS1 = 1'b1} srca_e;
  typedef enum logic       {PCSRC_ALU = 1'b0, PCSRC_ALUOUT = 1'b1} pcsrc_e;
  typedef enum logic [1:0] {ALUOP_ADD = 2'd0, ALUOP_BRANCH = 2'd1, ALUOP_FUNCT = 2'd2} aluop_e;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Memory handshake between the control FSM (master) and the memory port (slave).
interface multicycle_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic IorD;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output IorD, input mem_ready);
  modport slave  (input mem_req, input mem_we, input IorD, output mem_ready);
endinterface

// File: rtl/multicycle_control_fsm_decode.sv
// Combinational opcode classifier: instruction class plus a legal bit.
module rv32i_opcode_decode
  import rv32i_ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  output inst_class_e inst_class,
  output logic        legal
);

  always_comb begin
    inst_class = CL_NOP;
    legal      = 1'b1;
    case (opcode)
      OP_R:                inst_class = CL_R;
      OP_I:                inst_class = CL_I;
      OP_LOAD:             inst_class = CL_LOAD;
      OP_STORE:            inst_class = CL_STORE;
      OP_BRANCH:           inst_class = CL_BRANCH;
      OP_JAL:              inst_class = CL_JAL;
      OP_JALR:             inst_class = CL_JALR;
      OP_LUI:              inst_class = CL_LUI;
      OP_AUIPC:            inst_class = CL_AUIPC;
      OP_FENCE, OP_SYSTEM: inst_class = CL_NOP;
      default:             legal      = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main control FSM. Optional RV32I_ILLEGAL_TRAP_EN makes an
// unknown opcode lock into TRAP and adds the illegal output.
module multicycle_control_fsm
  import rv32i_ctrl_pkg::*;
#(
  parameter int unsigned STAGE_W = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_fsm_if.master  mem,
  input  logic [6:0]                opcode,
  input  logic                      branch_taken,
  output logic                      IRWrite,
  output logic                      PCWrite,
  output logic                      PCSrc,
  output logic [1:0]                alu_op,
  output logic                      RegWrite_reg,
  output logic [1:0]                MtoR_reg,
  output logic                      AluSrcA_reg,
  output logic [1:0]                AluSrcB_reg,
  output logic [STAGE_W-1:0]        current_stage
`ifdef RV32I_ILLEGAL_TRAP_EN
  ,output logic                     illegal
`endif
);

`ifdef RV32I_ILLEGAL_TRAP_EN
  localparam stage_e ILLEGAL_NEXT = S_TRAP;
`else
  localparam stage_e ILLEGAL_NEXT = S_FETCH;
`endif

  stage_e      state, state_next;
  inst_class_e inst_class;
  logic        legal;

  rv32i_opcode_decode u_decode (
    .opcode     (opcode),
    .inst_class (inst_class),
    .legal      (legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (mem.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (inst_class)
          CL_R:              state_next = S_EXEC_R;
          CL_I:              state_next = S_EXEC_I;
          CL_LOAD, CL_STORE: state_next = S_MEM_ADDR;
          CL_BRANCH:         state_next = S_BRANCH;
          CL_JAL:            state_next = S_JUMP;
          CL_JALR:           state_next = S_JALR_TGT;
          CL_LUI:            state_next = S_WB_U;
          CL_AUIPC:          state_next = S_WB_ALU;
          default:           state_next = legal ? S_FETCH : ILLEGAL_NEXT;
        endcase
      end
      S_EXEC_R:   state_next = S_WB_ALU;
      S_EXEC_I:   state_next = S_WB_I;
      S_MEM_ADDR: state_next = (inst_class == CL_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem.mem_ready) state_next = S_WB_LD;
      S_MEM_WR:   if (mem.mem_ready) state_next = S_FETCH;
      S_JALR_TGT: state_next = S_JUMP;
      S_JUMP:     state_next = S_WB_J;
      // TRAP self-holds only when trapping is built in; otherwise it is unreachable
      S_TRAP:     state_next = ILLEGAL_NEXT;
      default:    state_next = S_FETCH;
    endcase
  end

  // Reset gates every strobe combinationally so an in-flight request drops at once
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.IorD     = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    PCSrc        = PCSRC_ALU;
    alu_op       = ALUOP_ADD;
    RegWrite_reg = 1'b0;
    MtoR_reg     = MTOR_ALUOUT;
    AluSrcA_reg  = SRCA_PC;
    AluSrcB_reg  = SRCB_RS2;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          AluSrcB_reg = SRCB_FOUR;
          IRWrite     = mem.mem_ready;
          PCWrite     = mem.mem_ready;
        end
        S_DECODE:   AluSrcB_reg = SRCB_IMM;
        S_EXEC_R: begin
          AluSrcA_reg = SRCA_RS1;
          alu_op      = ALUOP_FUNCT;
        end
        S_EXEC_I: begin
          AluSrcA_reg = SRCA_RS1;
          AluSrcB_reg = SRCB_IMM;
          alu_op      = ALUOP_FUNCT;
        end
        S_MEM_ADDR, S_JALR_TGT: begin
          AluSrcA_reg = SRCA_RS1;
          AluSrcB_reg = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem.mem_req = 1'b1;
          mem.IorD    = 1'b1;
        end
        S_MEM_WR: begin
          mem.mem_req = 1'b1;
          mem.mem_we  = 1'b1;
          mem.IorD    = 1'b1;
        end
        S_BRANCH: begin
          AluSrcA_reg = SRCA_RS1;
          alu_op      = ALUOP_BRANCH;
          PCWrite     = branch_taken;
          PCSrc       = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          PCWrite     = 1'b1;
          PCSrc       = PCSRC_ALUOUT;
          AluSrcB_reg = SRCB_FOUR;
        end
        S_WB_ALU, S_WB_I, S_WB_J: RegWrite_reg = 1'b1;
        S_WB_LD: begin
          RegWrite_reg = 1'b1;
          MtoR_reg     = MTOR_LOAD;
        end
        S_WB_U: begin
          RegWrite_reg = 1'b1;
          MtoR_reg     = MTOR_IMM;
        end
        default: ;
      endcase
    end
  end

`ifdef RV32I_ILLEGAL_TRAP_EN
  assign illegal = !reset && (state == S_TRAP);
`endif

  assign current_stage = STAGE_W'(state);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed and random instruction streams
// checked against a per-instruction stage-sequence model.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       IRWrite, PCWrite, PCSrc, RegWrite_reg, AluSrcA_reg;
  logic [1:0] alu_op, MtoR_reg, AluSrcB_reg;
  logic [4:0] current_stage;
`ifdef RV32I_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  int exp_st[$];
  bit exp_rd[$];

  multicycle_control_fsm_if mif ();

  multicycle_control_fsm #(.STAGE_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem           (mif),
    .opcode        (opcode),
    .branch_taken  (branch_taken),
    .IRWrite       (IRWrite),
    .PCWrite       (PCWrite),
    .PCSrc         (PCSrc),
    .alu_op        (alu_op),
    .RegWrite_reg  (RegWrite_reg),
    .MtoR_reg      (MtoR_reg),
    .AluSrcA_reg   (AluSrcA_reg),
    .AluSrcB_reg   (AluSrcB_reg),
    .current_stage (current_stage)
`ifdef RV32I_ILLEGAL_TRAP_EN
    ,.illegal      (illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Stage walk of one instruction, built from the instruction-level rules
  task automatic build(input logic [6:0] op, input int fw, input int mw);
    exp_st.delete();
    exp_rd.delete();
    for (int i = 0; i < fw; i++) begin exp_st.push_back(0); exp_rd.push_back(0); end
    exp_st.push_back(0); exp_rd.push_back(1);
    exp_st.push_back(1); exp_rd.push_back(1'($urandom_range(0, 1)));
    case (op)
      7'b0110011: begin exp_st.push_back(2); exp_st.push_back(3); end
      7'b0010011: begin exp_st.push_back(5); exp_st.push_back(6); end
      7'b0000011: begin
        exp_st.push_back(4);
        for (int i = 0; i <= mw; i++) exp_st.push_back(7);
        exp_st.push_back(10);
      end
      7'b0100011: begin
        exp_st.push_back(4);
        for (int i = 0; i <= mw; i++) exp_st.push_back(8);
      end
      7'b1100011: exp_st.push_back(9);
      7'b1101111: begin exp_st.push_back(11); exp_st.push_back(12); end
      7'b1100111: begin exp_st.push_back(13); exp_st.push_back(11); exp_st.push_back(12); end
      7'b0110111: exp_st.push_back(14);
      7'b0010111: exp_st.push_back(3);
      7'b0001111, 7'b1110011: ;
      default: begin
`ifdef RV32I_ILLEGAL_TRAP_EN
        exp_st.push_back(15);
`endif
      end
    endcase
    // ready only matters in memory stages: complete on the last of each run
    for (int i = exp_rd.size(); i < exp_st.size(); i++) begin
      if (exp_st[i] == 7 || exp_st[i] == 8)
        exp_rd.push_back((i + 1 == exp_st.size()) || (exp_st[i+1] != exp_st[i]));
      else
        exp_rd.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic check_outputs(input int st, input bit rdy);
    bit pcw;
    pcw = (st == 0 && rdy) || st == 11 || (st == 9 && branch_taken);
    chk("stage",    32'(current_stage), 32'(st));
    chk("mem_req",  32'(mif.mem_req),   32'(st == 0 || st == 7 || st == 8));
    chk("mem_we",   32'(mif.mem_we),    32'(st == 8));
    chk("IorD",     32'(mif.IorD),      32'(st == 7 || st == 8));
    chk("RegWrite", 32'(RegWrite_reg),  32'(st == 3 || st == 6 || st == 10 || st == 12 || st == 14));
    chk("IRWrite",  32'(IRWrite),       32'(st == 0 && rdy));
    chk("PCWrite",  32'(PCWrite),       32'(pcw));
    chk("PCSrc",    32'(PCSrc),         32'(st == 9 || st == 11));
    chk("MtoR",     32'(MtoR_reg),      (st == 10) ? 32'd1 : (st == 14) ? 32'd2 : 32'd0);
    chk("alu_op",   32'(alu_op),        (st == 2 || st == 5) ? 32'd2 : (st == 9) ? 32'd1 : 32'd0);
`ifdef RV32I_ILLEGAL_TRAP_EN
    chk("illegal",  32'(illegal),       32'(st == 15));
`endif
  endtask

  // Entered just after a falling edge; leaves at the next falling edge
  task automatic step(input int st, input bit rdy);
    mif.mem_ready = rdy;
    branch_taken  = 1'($urandom_range(0, 1));
    #1;
    check_outputs(st, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_stage",   32'(current_stage), 32'd0);
    chk("rst_mem_req", 32'(mif.mem_req),   32'd0);
`ifdef RV32I_ILLEGAL_TRAP_EN
    chk("rst_illegal", 32'(illegal),       32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
    opcode = op;
    build(op, fw, mw);
    for (int i = 0; i < exp_st.size(); i++) step(exp_st[i], exp_rd[i]);
    if (exp_st[exp_st.size()-1] == 15) begin
      for (int i = 0; i < 3; i++) step(15, 1'($urandom_range(0, 1)));
      do_reset();
    end
  endtask

  logic [6:0] op_tab [15] = '{
    7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
    7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111,
    7'b1110011, 7'b0110011, 7'b0000011, 7'b0000000, 7'b1111111
  };

  initial begin
    reset         = 1'b1;
    opcode        = 7'b0110011;
    branch_taken  = 1'b1;
    mif.mem_ready = 1'b1;
    #1;
    chk("rst_stage",    32'(current_stage), 32'd0);
    chk("rst_mem_req",  32'(mif.mem_req),   32'd0);
    chk("rst_IRWrite",  32'(IRWrite),       32'd0);
    chk("rst_PCWrite",  32'(PCWrite),       32'd0);
    chk("rst_RegWrite", 32'(RegWrite_reg),  32'd0);
`ifdef RV32I_ILLEGAL_TRAP_EN
    chk("rst_illegal",  32'(illegal),       32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    run_instr(7'b0110011, 0, 0);
    run_instr(7'b0000011, 2, 2);
    run_instr(7'b1100011, 0, 0);
    run_instr(7'b1100111, 0, 0);
    run_instr(7'b0110111, 0, 0);
    run_instr(7'b0010111, 1, 0);
    run_instr(7'b0100011, 0, 1);
    run_instr(7'b0000000, 0, 0);

    // Store stalled in MEM_WR, then reset between clock edges
    opcode = 7'b0100011;
    build(7'b0100011, 0, 4);
    for (int i = 0; exp_st[i] != 8; i++) step(exp_st[i], exp_rd[i]);
    mif.mem_ready = 1'b0;
    #1;
    chk("mw_stage",   32'(current_stage), 32'd8);
    chk("mw_mem_req", 32'(mif.mem_req),   32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mw_rst_mem_req", 32'(mif.mem_req),   32'd0);
    chk("mw_rst_mem_we",  32'(mif.mem_we),    32'd0);
    chk("mw_rst_stage",   32'(current_stage), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 80; n++)
      run_instr(op_tab[$urandom_range(0, 14)], $urandom_range(0, 2), $urandom_range(0, 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
